// File: rtl/hrm_pkg.sv
// Shared definitions for the HRM datapath blocks: the default word width and the signed word type.
package hrm_pkg;

    localparam int WORD_WIDTH = 8;

    typedef logic signed [WORD_WIDTH-1:0] word_t;

endpackage

// File: rtl/outbox_if.sv
// Producer/consumer bundle between the control unit, the datapath and the OUTBOX FIFO.
interface outbox_if
    import hrm_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = WORD_WIDTH
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] iR;
    logic             wO;
    logic             oFull;
    logic [WIDTH-1:0] oData;
    logic             oValid;
    logic             iRd;
    logic [CW-1:0]    oCount;
    logic             oOverflow;

    modport master (
        output iR, wO, iRd,
        input  oFull, oData, oValid, oCount, oOverflow
    );

    modport slave (
        input  iR, wO, iRd,
        output oFull, oData, oValid, oCount, oOverflow
    );

endinterface

// File: rtl/outbox_mem.sv
// OUTBOX storage: DEPTH x WIDTH array, synchronous write, asynchronous read (gives fall-through output).
module outbox_mem
    import hrm_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = WORD_WIDTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/outbox.sv
// OUTBOX first-word-fall-through FIFO: pointer and occupancy control around outbox_mem.
// Define OUTBOX_OVERFLOW_EN to build the sticky dropped-push flag on oOverflow.
module outbox
    import hrm_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = WORD_WIDTH
) (
    input logic      clk,
    input logic      rst,
    outbox_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_pop;
    logic          do_push;

    // A pop frees a slot in the same edge, so a full FIFO still accepts a push alongside it.
    assign do_pop  = bus.oValid && bus.iRd;
    assign do_push = bus.wO && (!bus.oFull || do_pop);

    assign bus.oFull  = (count == CW'(DEPTH));
    assign bus.oValid = (count != '0);
    assign bus.oCount = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    outbox_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (do_push),
        .waddr (wr_ptr),
        .wdata (bus.iR),
        .raddr (rd_ptr),
        .rdata (bus.oData)
    );

`ifdef OUTBOX_OVERFLOW_EN
    logic overflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (bus.wO && !do_push) begin
            overflow <= 1'b1;
        end
    end

    assign bus.oOverflow = overflow;
`else
    assign bus.oOverflow = 1'b0;
`endif

endmodule

// File: doc/outbox.md
OUTBOX -- requirements
Module: outbox

Interface
REQ-001 SHALL take parameter DEPTH, default 8: number of FIFO entries; power of two, minimum 2.
REQ-002 SHALL take parameter WIDTH, default 8: data word width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port iR, input, WIDTH bits: signed register R value from the datapath.
REQ-006 SHALL have port wO, input, 1 bit: push strobe from the control unit, asserted on an OUTBOX instruction.
REQ-007 SHALL have port oFull, output, 1 bit: FIFO full; the control unit stalls on it.
REQ-008 SHALL have port oData, output, WIDTH bits: head entry, meaningful only while oValid=1.
REQ-009 SHALL have port oValid, output, 1 bit: FIFO non-empty.
REQ-010 SHALL have port iRd, input, 1 bit: consumer ready; pops the head when oValid=1.
REQ-011 SHALL have port oCount, output, log2(DEPTH)+1 bits: current occupancy.
REQ-012 SHALL have port oOverflow, output, 1 bit: sticky lost-push flag (see Configuration).

Function
REQ-013 SHALL be first-word-fall-through: oData equals the oldest stored entry whenever oValid=1, with no read latency.
REQ-014 SHALL pop on a rising edge when oValid=1 and iRd=1; iRd while empty SHALL be ignored (no underflow, count stays 0).
REQ-015 SHALL push iR on a rising edge when wO=1 and (oFull=0 or a pop occurs in the same cycle).
REQ-016 SHALL accept simultaneous push and pop when full: count stays DEPTH, and the new word enters behind the remaining entries.
REQ-017 SHALL not pass through when empty: a push with iRd=1 in the same cycle stores the word, sets oValid one cycle later, and performs no pop.
REQ-018 SHALL drop a push while full without a pop: storage and count unchanged.
REQ-019 SHALL keep read and write pointers modulo DEPTH, wrapping from DEPTH-1 to 0; full and empty SHALL be derived from oCount.
REQ-020 SHALL derive oFull = (oCount == DEPTH) and oValid = (oCount != 0) combinationally from registered state.
REQ-021 SHALL store data bit-exact; signed values such as -128 (8'h80) SHALL pass unmodified.

Reset
REQ-022 SHALL, when rst=1 at a clock edge, clear both pointers, oCount=0, oValid=0, oFull=0 and oOverflow=0; rst SHALL take priority over any simultaneous wO or iRd.
REQ-023 SHALL discard any queued data when rst asserts mid-operation; storage contents need not be cleared, and oData is don't-care while oValid=0.

Configuration
REQ-024 SHALL, with OUTBOX_OVERFLOW_EN defined, set oOverflow on any push dropped per REQ-018 and hold it until rst.
REQ-025 SHALL, without OUTBOX_OVERFLOW_EN, drive oOverflow constant 0 and implement no overflow register.

Structure
REQ-026 SHALL take the WIDTH default (8) and the word typedef from the shared package hrm_pkg, which the register and ALU blocks also use.
REQ-027 SHALL place storage in one sub-module, outbox_mem: a DEPTH x WIDTH array with synchronous write and asynchronous read; pointer and count logic stay in outbox.

Verification
REQ-028 SHALL cover reset then single push: rst 1 cycle, push 8'h2A with iRd=0 -> next cycle oValid=1, oData=8'h2A, oCount=1.
REQ-029 SHALL cover fill and overflow: 9 pushes 1..9 with iRd=0 and DEPTH=8 -> oFull=1 after the 8th, 9 dropped, and oOverflow=1 only if OUTBOX_OVERFLOW_EN is defined.
REQ-030 SHALL cover push and pop while full: push 8'hAA with iRd=1 -> count stays 8, then draining yields 2..8 followed by AA.
REQ-031 SHALL cover empty-cycle push with read: push 8'h80 with iRd=1 at count 0 -> no pop, next cycle oData=8'h80 and count=1.
REQ-032 SHALL cover pointer wrap: 20 interleaved push/pop operations across the DEPTH boundary -> output order equals input order with no loss.
REQ-033 SHALL cover reset mid-operation: rst at count=5 -> next cycle count=0, oValid=0, oOverflow=0, and wO/iRd in the reset cycle are ignored.
